// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the GPU memory path.
//   arb_state_t            - memory arbiter FSM state (IDLE / ISSUE)
//   REQ_VERTEX/COLOR/PIXEL - requester index of each pipeline stage
//   idx_width()            - bit width of an index into n items (at least 1)
package gpu_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    localparam int REQ_VERTEX = 0;
    localparam int REQ_COLOR  = 1;
    localparam int REQ_PIXEL  = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// id_fifo: synchronous FIFO holding the requester index of each accepted read,
// in issue order, so responses can be routed back.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   push, din  : write din at the tail (ignored when full without a pop)
//   pop, dout  : remove head; dout always shows the current head
//   count      : number of stored entries (0..DEPTH)
module id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Avalon-MM master between N_REQ pipeline requesters
// (0 vertex fetch, 1 color fetch, 2 pixel writeback). Single-beat commands are
// granted round-robin; read issuers are remembered in an in-order ID FIFO so
// each read response is routed back to its requester.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/write/addr/wdata : per-requester command, held until req_ready
//   req_ready           : one-cycle pulse when memory accepts the command
//   rsp_valid, rsp_data : one-cycle read response to the issuing requester
//   mem_*               : Avalon-MM master (read/write strobes, waitrequest,
//                         readdata/readdatavalid)
//   err_unexpected_rsp  : sticky, read data arrived with no read outstanding
//   dbg_state           : current arbiter FSM state
//
// Handshake: a requester raises req_valid with stable command fields and keeps
// them until the cycle req_ready pulses; that pulse coincides with the cycle
// the command is presented on mem_* with mem_waitrequest low.
module mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int N_REQ           = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_write,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_writedata,
    input  logic                             mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]            mem_readdata,
    input  logic                             mem_readdatavalid,
    output logic                             err_unexpected_rsp,
    output arb_state_t                       dbg_state
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_sel;
    logic [IDX_W-1:0] cand;
    logic             grant_found;
    logic [N_REQ-1:0] eligible;
    logic             cmd_accept;

    logic             fifo_push;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign dbg_state  = state;
    assign fifo_full  = (fifo_count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (fifo_count == '0);

    // ------------------------------------------------------------------
    // Round-robin search. Uses the registered FIFO count, so a response
    // popping a full FIFO in the same cycle does not yet unblock reads.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (req_write[i] || !fifo_full);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found)      state_next = ISSUE;
            ISSUE:   if (!mem_waitrequest) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        cmd_accept = 1'b0;
        if (state == ISSUE && !mem_waitrequest) begin
            cmd_accept       = 1'b1;
            req_ready[grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command register: loaded on grant, strobes dropped after acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            grant         <= '0;
            last          <= IDX_W'(N_REQ - 1);
        end else if (state == IDLE && grant_found) begin
            grant         <= grant_sel;
            mem_address   <= req_addr[grant_sel];
            mem_writedata <= req_wdata[grant_sel];
            mem_read      <= !req_write[grant_sel];
            mem_write     <= req_write[grant_sel];
        end else if (cmd_accept) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            last      <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Read ID tracking and response routing
    // ------------------------------------------------------------------
    assign fifo_push = cmd_accept && mem_read;
    assign fifo_pop  = mem_readdatavalid && !fifo_empty;

    id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid          <= '0;
            rsp_data           <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (mem_readdatavalid) begin
                if (fifo_empty) begin
                    err_unexpected_rsp <= 1'b1;
                end else begin
                    rsp_valid[fifo_dout] <= 1'b1;
                    rsp_data             <= mem_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    import gpu_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_write;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][DW-1:0] req_wdata;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 mem_read;
    logic                 mem_write;
    logic [AW-1:0]        mem_address;
    logic [DW-1:0]        mem_writedata;
    logic                 mem_waitrequest;
    logic [DW-1:0]        mem_readdata;
    logic                 mem_readdatavalid;
    logic                 err_unexpected_rsp;
    arb_state_t           dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .N_REQ           (NR),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_ready          (req_ready),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_writedata      (mem_writedata),
        .mem_waitrequest    (mem_waitrequest),
        .mem_readdata       (mem_readdata),
        .mem_readdatavalid  (mem_readdatavalid),
        .err_unexpected_rsp (err_unexpected_rsp),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        req_valid         = '0;
        req_write         = '0;
        req_addr          = '0;
        req_wdata         = '0;
        mem_waitrequest   = 1'b0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({req_ready, rsp_valid, mem_read, mem_write, err_unexpected_rsp} !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %0h required 0",
                     {req_ready, rsp_valid, mem_read, mem_write, err_unexpected_rsp});
        end
        n_cmp++;
        if ({mem_address, mem_writedata, rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h required 0", {mem_address, mem_writedata, rsp_data});
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0h required %0h", dbg_state, IDLE);
        end
    endtask

    task automatic test_single_read();
        req_valid[REQ_VERTEX] = 1'b1;
        req_write[REQ_VERTEX] = 1'b0;
        req_addr[REQ_VERTEX]  = 32'h100;
        tick();
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_strobe: got rd=%0b wr=%0b required rd=1 wr=0", mem_read, mem_write);
        end
        n_cmp++;
        if (mem_address !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_addr: got %0h required 100", mem_address);
        end
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL rd_ready: got %0b required 001", req_ready);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (mem_read !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rd_drop: got rd=%0b st=%0h required rd=0 st=0", mem_read, dbg_state);
        end
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'hCAFE;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL rd_rsp: got v=%0b d=%0h required v=001 d=cafe", rsp_valid, rsp_data);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 3'b000 || rsp_data !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL rd_rsp_hold: got v=%0b d=%0h required v=000 d=cafe", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 0, 1, 2};
        logic [NR-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_write[i] = 1'b1;
            req_addr[i]  = 32'h1000 + 32'(i) * 32'h10;
            req_wdata[i] = 32'hA000 + 32'(i);
        end
        req_valid = '1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_rdy = '0;
            if (c % 2 == 1) exp_rdy[order[(c - 1) / 2]] = 1'b1;
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_ready_c%0d: got %0b required %0b", c, req_ready, exp_rdy);
            end
            if (c % 2 == 1) begin
                n_cmp++;
                if (mem_write !== 1'b1 || mem_address !== 32'h1000 + 32'(order[(c - 1) / 2]) * 32'h10) begin
                    n_fail++;
                    $display("FAIL rr_cmd_c%0d: got wr=%0b addr=%0h", c, mem_write, mem_address);
                end
            end
            if (c == 11) req_valid = '0;
        end
    endtask

    task automatic test_waitrequest();
        req_valid[REQ_PIXEL] = 1'b1;
        req_write[REQ_PIXEL] = 1'b1;
        req_addr[REQ_PIXEL]  = 32'h2000;
        req_wdata[REQ_PIXEL] = 32'hDEADBEEF;
        mem_waitrequest      = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (req_ready !== 3'b000 || mem_write !== 1'b1 ||
                mem_address !== 32'h2000 || mem_writedata !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL wait_hold_%0d: got rdy=%0b wr=%0b a=%0h d=%0h", k, req_ready,
                         mem_write, mem_address, mem_writedata);
            end
            tick();
        end
        mem_waitrequest = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL wait_release: got %0b required 100", req_ready);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (mem_write !== 1'b0 || req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL wait_done: got wr=%0b rdy=%0b required 0", mem_write, req_ready);
        end
    endtask

    task automatic test_outstanding_limit();
        int n_acc = 0;
        req_valid[REQ_COLOR] = 1'b1;
        req_write[REQ_COLOR] = 1'b0;
        req_addr[REQ_COLOR]  = 32'h3000;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (req_ready[REQ_COLOR] === 1'b1) n_acc++;
        end
        n_cmp++;
        if (n_acc != 4) begin
            n_fail++;
            $display("FAIL lim_accepted: got %0d required 4", n_acc);
        end
        n_cmp++;
        if (dbg_state !== IDLE || mem_read !== 1'b0 || req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL lim_stalled: got st=%0h rd=%0b rdy=%0b", dbg_state, mem_read, req_ready);
        end
        req_valid[REQ_PIXEL] = 1'b1;
        req_write[REQ_PIXEL] = 1'b1;
        req_addr[REQ_PIXEL]  = 32'h4000;
        tick();
        n_cmp++;
        if (mem_write !== 1'b1 || req_ready !== 3'b100 || mem_address !== 32'h4000) begin
            n_fail++;
            $display("FAIL lim_write: got wr=%0b rdy=%0b a=%0h", mem_write, req_ready, mem_address);
        end
        req_valid[REQ_PIXEL] = 1'b0;
        tick();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h1111;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'h1111) begin
            n_fail++;
            $display("FAIL lim_rsp: got v=%0b d=%0h required 010/1111", rsp_valid, rsp_data);
        end
        n_cmp++;
        if (dbg_state !== IDLE || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL lim_same_cycle_pop: got st=%0h rd=%0b required idle", dbg_state, mem_read);
        end
        tick();
        n_cmp++;
        if (mem_read !== 1'b1 || req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL lim_fifth: got rd=%0b rdy=%0b required 1/010", mem_read, req_ready);
        end
        req_valid = '0;
        tick();
        mem_readdatavalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_readdata = 32'h5000 + 32'(k);
            tick();
            n_cmp++;
            if (rsp_valid !== 3'b010 || rsp_data !== 32'h5000 + 32'(k)) begin
                n_fail++;
                $display("FAIL lim_drain_%0d: got v=%0b d=%0h", k, rsp_valid, rsp_data);
            end
        end
        mem_readdatavalid = 1'b0;
        tick();
        n_cmp++;
        if (rsp_valid !== 3'b000 || err_unexpected_rsp !== 1'b0) begin
            n_fail++;
            $display("FAIL lim_end: got v=%0b err=%0b required 0/0", rsp_valid, err_unexpected_rsp);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        tick();
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_ready0: got %0b required 001", req_ready);
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h20;
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 3'b010 || mem_address !== 32'h20) begin
            n_fail++;
            $display("FAIL b2b_ready1: got rdy=%0b a=%0h", req_ready, mem_address);
        end
        // Response D0 arrives in the same cycle read 1 is accepted.
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h30;
        mem_readdatavalid = 1'b1; mem_readdata = 32'hD0;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'hD0) begin
            n_fail++;
            $display("FAIL b2b_rsp0: got v=%0b d=%0h required 001/d0", rsp_valid, rsp_data);
        end
        tick();
        n_cmp++;
        if (req_ready !== 3'b100 || mem_address !== 32'h30) begin
            n_fail++;
            $display("FAIL b2b_ready2: got rdy=%0b a=%0h", req_ready, mem_address);
        end
        req_valid[2] = 1'b0;
        mem_readdatavalid = 1'b1; mem_readdata = 32'hD1;
        tick();
        n_cmp++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'hD1) begin
            n_fail++;
            $display("FAIL b2b_rsp1: got v=%0b d=%0h required 010/d1", rsp_valid, rsp_data);
        end
        mem_readdata = 32'hD2;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 3'b100 || rsp_data !== 32'hD2) begin
            n_fail++;
            $display("FAIL b2b_rsp2: got v=%0b d=%0h required 100/d2", rsp_valid, rsp_data);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 3'b000 || rsp_data !== 32'hD2 || err_unexpected_rsp !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got v=%0b d=%0h err=%0b", rsp_valid, rsp_data, err_unexpected_rsp);
        end
    endtask

    task automatic test_unexpected_and_reset();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h5555;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (err_unexpected_rsp !== 1'b1 || rsp_valid !== 3'b000 || rsp_data !== 32'hD2) begin
            n_fail++;
            $display("FAIL unexp_rsp: got err=%0b v=%0b d=%0h required 1/000/d2",
                     err_unexpected_rsp, rsp_valid, rsp_data);
        end
        tick();
        n_cmp++;
        if (err_unexpected_rsp !== 1'b1) begin
            n_fail++;
            $display("FAIL unexp_sticky: got %0b required 1", err_unexpected_rsp);
        end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h6000;
        mem_waitrequest = 1'b1;
        tick();
        n_cmp++;
        if (dbg_state !== ISSUE || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_issue: got st=%0h wr=%0b required 1/1", dbg_state, mem_write);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = '0;
        mem_waitrequest = 1'b0;
        n_cmp++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || err_unexpected_rsp !== 1'b0 ||
            dbg_state !== IDLE || req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_issue: got rd=%0b wr=%0b err=%0b st=%0h rdy=%0b",
                     mem_read, mem_write, err_unexpected_rsp, dbg_state, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_waitrequest();
        test_outstanding_limit();
        test_back_to_back();
        test_unexpected_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
